i2c_codec_responder: RTL and testbench

//  I2C target that answers the 3-byte codec register write the config master sends
//  (START, addr 7'h1a+W, {reg[6:0],data[8]}, data[7:0], STOP).

---
 rtl/i2c_codec_responder_pkg.sv | 24 ++
 rtl/i2c_codec_responder_if.sv | 10 +
 rtl/i2c_codec_responder_bus_sync.sv | 50 +++++
 rtl/i2c_codec_responder.sv | 158 +++++++++++++++
 tb/tb_i2c_codec_responder.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/i2c_codec_responder_pkg.sv
// Shared definitions for the codec config master and the codec responder:
// frame state encodings, codec target address and codec register indices.
package i2c_codec_responder_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_BYTE1    = 4'd3,
        ST_ACK1     = 4'd4,
        ST_BYTE2    = 4'd5,
        ST_ACK2     = 4'd6,
        ST_DONE     = 4'd7,
        ST_IGNORE   = 4'd8
    } i2c_frame_state_t;

    localparam logic [6:0] CODEC_DEVADDR    = 7'h1a;
    localparam logic [6:0] CODEC_RESET_REG  = 7'h0F;
    localparam logic [6:0] CODEC_REG_POWER  = 7'h06;
    localparam logic [6:0] CODEC_REG_ANALOG = 7'h04;

    localparam int SHADOW_DEPTH = 16;

endpackage

// File: rtl/i2c_codec_responder_if.sv
// I2C bus as seen by the codec responder. sda_in is the wired-AND bus level,
// sda_oe is the responder's open-drain pull-down request.
interface i2c_codec_responder_if;
    logic scl;
    logic sda_in;
    logic sda_oe;

    modport master (output scl, output sda_in, input sda_oe);
    modport slave  (input scl, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_codec_responder_bus_sync.sv
// SCL/SDA synchroniser with a history flop per line, producing SCL edge
// strobes and START/STOP strobes from the synchronised signals only.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_h;
    logic                   sda_h;
    logic                   scl_s;

    // Synchroniser chains plus history; reset to the idle-bus level so no
    // spurious edges appear when reset is released on an idle bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_h    <= 1'b1;
            sda_h    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_h    <= scl_sync[SYNC_STAGES-1];
            sda_h    <= sda_sync[SYNC_STAGES-1];
        end
    end

    // Edge and bus-condition decode; SCL must be high on both samples so an
    // SDA move that coincides with an SCL fall is not taken as START/STOP.
    always_comb begin
        scl_s     = scl_sync[SYNC_STAGES-1];
        sda_s     = sda_sync[SYNC_STAGES-1];
        scl_rise  = scl_s & ~scl_h;
        scl_fall  = ~scl_s & scl_h;
        start_det = scl_s & scl_h & sda_h & ~sda_s;
        stop_det  = scl_s & scl_h & ~sda_h & sda_s;
    end

endmodule

// File: rtl/i2c_codec_responder.sv
// I2C codec stand-in: ACKs 3-byte register writes to DEVADDR, strobes each
// decoded write and keeps a 16x9 shadow register file.
//
//  state       | meaning
//  ------------+----------------------------------------------
//  ST_IDLE     | bus free, waiting for START
//  ST_ADDR     | shifting address byte
//  ST_ADDR_ACK | driving ACK for matching address
//  ST_BYTE1    | shifting {reg[6:0], data[8]}
//  ST_ACK1     | driving ACK for byte 1
//  ST_BYTE2    | shifting data[7:0]
//  ST_ACK2     | driving ACK for byte 2; commit on its closing SCL fall
//  ST_DONE     | frame committed, extra bytes NACKed until STOP
//  ST_IGNORE   | not addressed to us, NACK until STOP
module i2c_codec_responder
    import i2c_codec_responder_pkg::*;
#(
    parameter logic [6:0] DEVADDR     = CODEC_DEVADDR,
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] RESET_REG   = CODEC_RESET_REG
) (
    input  logic                 clk,
    input  logic                 reset,
    i2c_codec_responder_if.slave bus,
    output logic                 wr_valid,
    output logic [6:0]           wr_addr,
    output logic [8:0]           wr_data,
    output logic                 frame_err,
    output logic                 busy,
    input  logic [3:0]           rd_addr,
    output logic [8:0]           rd_data
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl       (bus.scl),
        .sda_in    (bus.sda_in),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_frame_state_t state, state_nxt;
    logic [3:0]       bit_cnt;
    logic [7:0]       shreg;
    logic [7:0]       byte1;
    logic             commit;
    logic             abort;
    logic             in_frame;
    logic             shifting;
    logic             ack_nxt;
    logic [8:0]       shadow [SHADOW_DEPTH];

    // Next-state decode; START/STOP pre-empt any bit-level activity.
    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        in_frame  = state inside {ST_ADDR_ACK, ST_BYTE1, ST_ACK1, ST_BYTE2, ST_ACK2};
        shifting  = state inside {ST_ADDR, ST_BYTE1, ST_BYTE2};
        abort     = 1'b0;
        if (stop_det) begin
            state_nxt = ST_IDLE;
            abort     = in_frame;
        end else if (start_det) begin
            state_nxt = ST_ADDR;
            abort     = in_frame;
        end else if (scl_fall) begin
            case (state)
                ST_ADDR: begin
                    if (bit_cnt == 4'd8)
                        state_nxt = (shreg == {DEVADDR, 1'b0}) ? ST_ADDR_ACK : ST_IGNORE;
                end
                ST_ADDR_ACK: state_nxt = ST_BYTE1;
                ST_BYTE1: begin
                    if (bit_cnt == 4'd8) state_nxt = ST_ACK1;
                end
                ST_ACK1: state_nxt = ST_BYTE2;
                ST_BYTE2: begin
                    if (bit_cnt == 4'd8) state_nxt = ST_ACK2;
                end
                ST_ACK2: begin
                    state_nxt = ST_DONE;
                    commit    = 1'b1;
                end
                default: ;
            endcase
        end
        ack_nxt = state_nxt inside {ST_ADDR_ACK, ST_ACK1, ST_ACK2};
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Bit counter, shift register and captured first data byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= 4'd0;
            shreg   <= 8'd0;
            byte1   <= 8'd0;
        end else begin
            if (state_nxt != state || start_det || stop_det) begin
                bit_cnt <= 4'd0;
            end else if (scl_rise && shifting) begin
                shreg   <= {shreg[6:0], sda_s};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (state == ST_BYTE1 && state_nxt == ST_ACK1)
                byte1 <= shreg;
        end
    end

    // Registered bus-facing and status outputs; reset releases SDA at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.sda_oe <= 1'b0;
            busy       <= 1'b0;
            wr_valid   <= 1'b0;
            frame_err  <= 1'b0;
            wr_addr    <= 7'd0;
            wr_data    <= 9'd0;
        end else begin
            bus.sda_oe <= ack_nxt;
            wr_valid   <= commit;
            frame_err  <= abort;
            if (start_det)     busy <= 1'b1;
            else if (stop_det) busy <= 1'b0;
            if (commit) begin
                wr_addr <= byte1[7:1];
                wr_data <= {byte1[0], shreg};
            end
        end
    end

    // Shadow file: a write to RESET_REG wipes every entry, other in-range
    // indices update one entry, out-of-range indices are only strobed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SHADOW_DEPTH; i++) shadow[i] <= 9'd0;
        end else if (commit) begin
            if (byte1[7:1] == RESET_REG) begin
                for (int i = 0; i < SHADOW_DEPTH; i++) shadow[i] <= 9'd0;
            end else if (byte1[7:5] == 3'd0) begin
                shadow[byte1[4:1]] <= {byte1[0], shreg};
            end
        end
    end

    assign rd_data = shadow[rd_addr];

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench: bit-banged I2C master with open-drain wired-AND bus.
module tb_i2c_codec_responder;
    import i2c_codec_responder_pkg::*;

    localparam int Q = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       wr_valid, frame_err, busy;
    logic [6:0] wr_addr;
    logic [8:0] wr_data, rd_data;
    logic [3:0] rd_addr = 4'd0;

    int n_chk = 0, n_pass = 0;
    int n_wr = 0, n_err = 0, n_oe = 0;

    i2c_codec_responder_if bus ();
    assign bus.scl    = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    i2c_codec_responder dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err),
        .busy      (busy),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (wr_valid)   n_wr++;
        if (frame_err)  n_err++;
        if (bus.sda_oe) n_oe++;
    end

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic qwait();
        repeat (Q) @(posedge clk);
    endtask

    task automatic rd(input logic [3:0] a, output logic [8:0] d);
        @(negedge clk);
        rd_addr = a;
        #1;
        d = rd_data;
    endtask

    task automatic start_cond();
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b1; qwait();
    endtask

    task automatic bitxmit(input logic b, output logic seen);
        sda_m = b;    qwait();
        scl_m = 1'b1; qwait();
        seen  = bus.sda_in;
        qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic send_bits(input logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) bitxmit(b[i], s);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        send_bits(b);
        bitxmit(1'b1, s);
        ack = ~s;
    endtask

    task automatic i2cgenerator(input logic [6:0] a, input logic [8:0] d, output logic [2:0] acks);
        start_cond();
        send_byte({CODEC_DEVADDR, 1'b0}, acks[2]);
        send_byte({a, d[8]}, acks[1]);
        send_byte(d[7:0], acks[0]);
        stop_cond();
    endtask

    initial begin
        logic [2:0] acks;
        logic       a;
        logic [8:0] d;
        int         w0, e0, o0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_sda_oe", bus.sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        rd(4'd6, d); chk("rst_shadow6", d, 0);

        // 1: power register write
        w0 = n_wr;
        i2cgenerator(CODEC_REG_POWER, 9'h00E, acks);
        @(negedge clk);
        chk("t1_acks", acks, 3'b111);
        chk("t1_wr_cnt", n_wr - w0, 1);
        chk("t1_wr_addr", wr_addr, 7'h06);
        chk("t1_wr_data", wr_data, 9'h00E);
        chk("t1_busy", busy, 0);
        rd(4'd6, d); chk("t1_shadow6", d, 9'h00E);

        // 2: analogue path then reset register
        i2cgenerator(CODEC_REG_ANALOG, 9'h00A, acks);
        rd(4'd4, d); chk("t2_shadow4", d, 9'h00A);
        rd(4'd6, d); chk("t2_shadow6_kept", d, 9'h00E);
        i2cgenerator(CODEC_RESET_REG, 9'h000, acks);
        chk("t2_wr_addr", wr_addr, 7'h0F);
        rd(4'd4, d); chk("t2_clr4", d, 0);
        rd(4'd6, d); chk("t2_clr6", d, 0);

        // out-of-range index: strobe only
        w0 = n_wr;
        i2cgenerator(7'h20, 9'h155, acks);
        chk("oor_wr_cnt", n_wr - w0, 1);
        chk("oor_wr_data", wr_data, 9'h155);
        rd(4'd0, d); chk("oor_shadow0", d, 0);

        // 3: wrong address
        w0 = n_wr; o0 = n_oe;
        start_cond();
        send_byte({7'h1b, 1'b0}, a);
        chk("t3_ack", a, 0);
        send_byte(8'h55, a);
        send_byte(8'h1C, a);
        stop_cond();
        @(negedge clk);
        chk("t3_wr_cnt", n_wr - w0, 0);
        chk("t3_oe_cnt", n_oe - o0, 0);

        // 4: read to our address
        start_cond();
        send_byte(8'h35, a);
        chk("t4_ack", a, 0);
        @(negedge clk);
        chk("t4_busy_mid", busy, 1);
        send_byte(8'hA5, a);
        chk("t4_ack2", a, 0);
        stop_cond();
        @(negedge clk);
        chk("t4_busy_end", busy, 0);

        // 5: STOP after byte-1 ACK
        i2cgenerator(CODEC_REG_POWER, 9'h123, acks);
        w0 = n_wr; e0 = n_err;
        start_cond();
        send_byte({CODEC_DEVADDR, 1'b0}, a);
        send_byte({CODEC_REG_POWER, 1'b0}, a);
        chk("t5_ack1", a, 1);
        stop_cond();
        @(negedge clk);
        chk("t5_err_cnt", n_err - e0, 1);
        chk("t5_wr_cnt", n_wr - w0, 0);
        rd(4'd6, d); chk("t5_shadow6", d, 9'h123);

        // 6: reset while driving ACK1
        start_cond();
        send_byte({CODEC_DEVADDR, 1'b0}, a);
        send_bits({CODEC_REG_ANALOG, 1'b1});
        @(negedge clk);
        chk("t6_oe_ack1", bus.sda_oe, 1);
        reset = 1'b0;
        #1;
        chk("t6_oe_rst", bus.sda_oe, 0);
        chk("t6_busy_rst", busy, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        stop_cond();
        rd(4'd6, d); chk("t6_shadow6_rst", d, 0);
        w0 = n_wr;
        i2cgenerator(CODEC_REG_ANALOG, 9'h1AB, acks);
        chk("t6_acks", acks, 3'b111);
        chk("t6_wr_cnt", n_wr - w0, 1);
        chk("t6_wr_data", wr_data, 9'h1AB);
        rd(4'd4, d); chk("t6_shadow4", d, 9'h1AB);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
